ahb_slave_responder: RTL and testbench
======================================

# ahb_slave_responder

Bus slave responder for the two-master/two-slave shared bus. It decodes a selected transfer and performs the access on a local register-file memory. It drives the ready/response/split handshake that the bus controller samples, and implements wait states, ERROR, RETRY and SPLIT responses. One instance sits behind each slave select (sel1/sel2) and feeds rdyout/respout/split back to the controller.

## Interface
- ADDR_W, 5, address width
- DATA_W, 8, data width
- DEPTH, 16, implemented words; valid addresses 0..DEPTH-1
- SPLIT_BASE, 8, reads at addr >= SPLIT_BASE (and < DEPTH) are split
- RO_BASE, 12, addresses >= RO_BASE (and < DEPTH) are read-only
- WAIT_CYCLES, 2, wait states for a normal access (0 allowed)
- SPLIT_LAT, 4, cycles split is held before completion (>= 1)

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- sel  in  1  slave select from controller, sampled only in IDLE
- addr_in  in  ADDR_W  transfer address
- wdata  in  DATA_W  write data, sampled with sel
- read_write  in  1  1 = write, 0 = read
- busy  in  1  local resource busy, forces RETRY
- rdata  out  DATA_W  read data, valid while rdyout=1 and respout=OKAY in DATA
- rdyout  out  1  transfer ready / slave free
- respout  out  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- split  out  1  split in progress

## Operation
- States: IDLE, WAIT, DATA, ERR, RTY, SPLIT_HOLD. All outputs are registered and decoded from the state.
- Reset values: state IDLE, rdyout=1, respout=00, split=0, rdata=0, all memory words 0, counters 0.
- In IDLE (rdyout=1, OKAY, split=0): on sel=1, latch addr_in, wdata and read_write, then classify. Priority is highest first:
  1. addr >= DEPTH -> ERR
  2. write with addr >= RO_BASE -> ERR
  3. busy=1 -> RTY
  4. read with addr >= SPLIT_BASE -> SPLIT_HOLD, counter loaded with SPLIT_LAT-1
  5. otherwise -> WAIT, counter loaded with WAIT_CYCLES-1; if WAIT_CYCLES=0, go straight to DATA
- WAIT: rdyout=0, respout=OKAY. Decrement the counter and go to DATA when it reads 0.
- DATA: rdyout=1, respout=OKAY.
  - Write: commit the memory write on the edge that enters DATA.
  - Read: rdata is loaded from memory on the edge that enters DATA and holds until the next read.
  - Next state is IDLE.
- ERR: rdyout=1, respout=ERROR, one cycle, no memory access, rdata unchanged. Next state IDLE.
- RTY: rdyout=1, respout=RETRY, one cycle, no access. Next state IDLE; the master re-issues.
- SPLIT_HOLD: rdyout=0, respout=SPLIT, split=1. Decrement the counter; at 0 go to DATA and complete the read normally.
- sel is ignored outside IDLE. A new transfer is accepted only in the cycle after DATA/ERR/RTY returns to IDLE.
- busy is sampled only at classification. Deasserting it mid-transfer has no effect.

## Timing
- sel sampled high at edge N in IDLE. Outputs after edge N+1 (defaults):
  - normal: WAIT for 2 cycles (rdyout=0), DATA after edge N+3, IDLE after edge N+4
  - WAIT_CYCLES=0: DATA after edge N+1
  - ERR/RTY: response visible after edge N+1 for exactly one cycle
  - split: split=1 after edges N+1..N+4, DATA after edge N+5
- A write is visible to a read issued in the following IDLE cycle. There is no bypass hazard.
- Reset asserted in any state returns to IDLE immediately, asynchronously: rdyout=1, respout=00, split=0, memory cleared, and any in-flight write is dropped.
- Back-to-back transfers: minimum spacing is 1 IDLE cycle between DATA and the next accepted sel.

## Test plan
- Reset -> rdyout=1, respout=00, split=0, rdata=00. Read addr 3 -> rdata=00.
- Write 8'hA5 to addr 3, then read addr 3 -> rdyout low 2 cycles, then DATA with respout=00, rdata=A5, then IDLE.
- Read addr 20 (>= DEPTH); write 8'h11 to addr 13 (read-only) -> one cycle respout=01 with rdyout=1 for each; a later read of addr 13 returns 00.
- busy=1 with sel for a read of addr 2 -> one cycle respout=10, no access. Re-issue with busy=0 -> normal OKAY completion.
- Write 8'h3C to addr 9, then read addr 9 -> split=1 and respout=11 for 4 cycles with rdyout=0, then DATA with rdata=3C, respout=00.
- rst pulsed during WAIT of a write of 8'hFF to addr 5 -> immediately IDLE outputs; a subsequent read of addr 5 returns 00.

Source files
------------

// File: rtl/ahb_slave_responder_if.sv
// rtl/ahb_slave_responder_if.sv - transfer request/response bundle between bus controller and slave responder
interface ahb_slave_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              sel;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic              read_write;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rdyout;
  logic [1:0]        respout;
  logic              split;

  modport master (
    output sel, addr_in, wdata, read_write, busy,
    input  rdata, rdyout, respout, split
  );

  modport slave (
    input  sel, addr_in, wdata, read_write, busy,
    output rdata, rdyout, respout, split
  );
endinterface

// File: rtl/ahb_slave_responder.sv
// rtl/ahb_slave_responder.sv - slave responder with wait states, ERROR/RETRY/SPLIT responses over a local register file
module ahb_slave_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SPLIT_BASE  = 8,
  parameter int RO_BASE     = 12,
  parameter int WAIT_CYCLES = 2,
  parameter int SPLIT_LAT   = 4
) (
  input logic                  clk,
  input logic                  rst,
  ahb_slave_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 8;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR, S_RTY, S_SPLIT_HOLD
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdyout;
  logic [1:0]        r_respout;
  logic              r_split;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic              w_ro_hit;
  logic              w_split_hit;
  logic              w_normal;
  logic              w_enter_data;
  logic [IDX_W-1:0]  w_acc_idx;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_rw;

  assign w_in_range  = int'(bus.addr_in) < DEPTH;
  assign w_ro_hit    = int'(bus.addr_in) >= RO_BASE;
  assign w_split_hit = int'(bus.addr_in) >= SPLIT_BASE;
  assign w_normal    = w_in_range && !(bus.read_write && w_ro_hit) && !bus.busy &&
                       !(!bus.read_write && w_split_hit);

  // With zero wait states the access happens straight out of IDLE, so it uses the live inputs.
  assign w_enter_data = ((r_state == S_IDLE) && bus.sel && w_normal && (WAIT_CYCLES == 0)) ||
                        (((r_state == S_WAIT) || (r_state == S_SPLIT_HOLD)) && (r_cnt == '0));
  assign w_acc_idx    = (r_state == S_IDLE) ? bus.addr_in[IDX_W-1:0] : r_addr;
  assign w_acc_wdata  = (r_state == S_IDLE) ? bus.wdata : r_wdata;
  assign w_acc_rw     = (r_state == S_IDLE) ? bus.read_write : r_rw;

  function automatic logic [3:0] f_outs(input state_t s);
    case (s)
      S_WAIT:       f_outs = {1'b0, RESP_OKAY,  1'b0};
      S_ERR:        f_outs = {1'b1, RESP_ERROR, 1'b0};
      S_RTY:        f_outs = {1'b1, RESP_RETRY, 1'b0};
      S_SPLIT_HOLD: f_outs = {1'b0, RESP_SPLIT, 1'b1};
      default:      f_outs = {1'b1, RESP_OKAY,  1'b0};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_rdata   <= '0;
      r_rdyout  <= 1'b1;
      r_respout <= RESP_OKAY;
      r_split   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.sel) begin
            r_addr  <= bus.addr_in[IDX_W-1:0];
            r_wdata <= bus.wdata;
            r_rw    <= bus.read_write;
            if (!w_in_range || (bus.read_write && w_ro_hit)) begin
              r_state <= S_ERR;
              {r_rdyout, r_respout, r_split} <= f_outs(S_ERR);
            end else if (bus.busy) begin
              r_state <= S_RTY;
              {r_rdyout, r_respout, r_split} <= f_outs(S_RTY);
            end else if (!bus.read_write && w_split_hit) begin
              r_state <= S_SPLIT_HOLD;
              r_cnt   <= CNT_W'(SPLIT_LAT - 1);
              {r_rdyout, r_respout, r_split} <= f_outs(S_SPLIT_HOLD);
            end else if (WAIT_CYCLES == 0) begin
              r_state <= S_DATA;
              {r_rdyout, r_respout, r_split} <= f_outs(S_DATA);
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
              {r_rdyout, r_respout, r_split} <= f_outs(S_WAIT);
            end
          end
        end
        S_WAIT, S_SPLIT_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_DATA;
            {r_rdyout, r_respout, r_split} <= f_outs(S_DATA);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          {r_rdyout, r_respout, r_split} <= f_outs(S_IDLE);
        end
      endcase

      if (w_enter_data) begin
        if (w_acc_rw) r_mem[w_acc_idx] <= w_acc_wdata;
        else          r_rdata <= r_mem[w_acc_idx];
      end
    end
  end

  assign bus.rdata   = r_rdata;
  assign bus.rdyout  = r_rdyout;
  assign bus.respout = r_respout;
  assign bus.split   = r_split;
endmodule

// File: tb/tb_ahb_slave_responder.sv
// tb/tb_ahb_slave_responder.sv - directed bench for the slave responder
module tb_ahb_slave_responder;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ahb_slave_responder_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ahb_slave_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [4:0] addr, input logic [7:0] wd, input logic bz);
    bus.sel        = 1'b1;
    bus.read_write = rw;
    bus.addr_in    = addr;
    bus.wdata      = wd;
    bus.busy       = bz;
    step();
    bus.sel     = 1'b0;
    bus.busy    = 1'b0;
    bus.addr_in = '0;
    bus.wdata   = '0;
  endtask

  task automatic normal(input string tag, input logic rw, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    issue(rw, addr, wd, 1'b0);
    chk({tag, " wait1 rdy"}, 32'(bus.rdyout), 32'd0);
    chk({tag, " wait1 resp"}, 32'(bus.respout), 32'd0);
    step();
    chk({tag, " wait2 rdy"}, 32'(bus.rdyout), 32'd0);
    step();
    chk({tag, " data rdy"}, 32'(bus.rdyout), 32'd1);
    chk({tag, " data resp"}, 32'(bus.respout), 32'd0);
    if (!rw) chk({tag, " data rdata"}, 32'(bus.rdata), 32'(exp_rd));
    step();
    chk({tag, " idle rdy"}, 32'(bus.rdyout), 32'd1);
  endtask

  task automatic split_read(input string tag, input logic [4:0] addr, input logic [7:0] exp_rd);
    issue(1'b0, addr, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " hold split"}, 32'(bus.split), 32'd1);
      chk({tag, " hold resp"}, 32'(bus.respout), 32'd3);
      chk({tag, " hold rdy"}, 32'(bus.rdyout), 32'd0);
      step();
    end
    chk({tag, " data split"}, 32'(bus.split), 32'd0);
    chk({tag, " data rdy"}, 32'(bus.rdyout), 32'd1);
    chk({tag, " data resp"}, 32'(bus.respout), 32'd0);
    chk({tag, " data rdata"}, 32'(bus.rdata), 32'(exp_rd));
    step();
    chk({tag, " idle rdy"}, 32'(bus.rdyout), 32'd1);
  endtask

  task automatic one_cycle_resp(input string tag, input logic rw, input logic [4:0] addr,
                                input logic [7:0] wd, input logic bz, input logic [1:0] exp_resp);
    issue(rw, addr, wd, bz);
    chk({tag, " rdy"}, 32'(bus.rdyout), 32'd1);
    chk({tag, " resp"}, 32'(bus.respout), 32'(exp_resp));
    step();
    chk({tag, " after resp"}, 32'(bus.respout), 32'd0);
    chk({tag, " after rdy"}, 32'(bus.rdyout), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.sel        = 1'b0;
    bus.addr_in    = '0;
    bus.wdata      = '0;
    bus.read_write = 1'b0;
    bus.busy       = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset rdy", 32'(bus.rdyout), 32'd1);
    chk("reset resp", 32'(bus.respout), 32'd0);
    chk("reset split", 32'(bus.split), 32'd0);
    chk("reset rdata", 32'(bus.rdata), 32'd0);

    normal("rd3 init", 1'b0, 5'd3, 8'h00, 8'h00);
    normal("wr3 A5", 1'b1, 5'd3, 8'hA5, 8'h00);
    normal("rd3 A5", 1'b0, 5'd3, 8'h00, 8'hA5);

    one_cycle_resp("rd20 err", 1'b0, 5'd20, 8'h00, 1'b0, 2'b01);
    chk("err rdata kept", 32'(bus.rdata), 32'hA5);
    one_cycle_resp("wr13 ro err", 1'b1, 5'd13, 8'h11, 1'b0, 2'b01);
    split_read("rd13", 5'd13, 8'h00);

    one_cycle_resp("rd2 busy", 1'b0, 5'd2, 8'h00, 1'b1, 2'b10);
    chk("retry rdata kept", 32'(bus.rdata), 32'h00);
    normal("rd2 reissue", 1'b0, 5'd2, 8'h00, 8'h00);

    normal("wr9 3C", 1'b1, 5'd9, 8'h3C, 8'h00);
    split_read("rd9", 5'd9, 8'h3C);

    normal("wr4 5A", 1'b1, 5'd4, 8'h5A, 8'h00);
    normal("rd4 5A", 1'b0, 5'd4, 8'h00, 8'h5A);

    issue(1'b1, 5'd5, 8'hFF, 1'b0);
    chk("wr5 in wait", 32'(bus.rdyout), 32'd0);
    rst = 1'b1;
    #1;
    chk("async rst rdy", 32'(bus.rdyout), 32'd1);
    chk("async rst resp", 32'(bus.respout), 32'd0);
    chk("async rst split", 32'(bus.split), 32'd0);
    chk("async rst rdata", 32'(bus.rdata), 32'd0);
    step();
    rst = 1'b0;
    step();
    normal("rd5 dropped", 1'b0, 5'd5, 8'h00, 8'h00);
    normal("rd4 cleared", 1'b0, 5'd4, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
